// File: rtl/fpu_issue_controller_pkg.sv
// fpu_issue_controller_pkg
//   Shared definitions for the FPU issue stage: FPU opcodes, issue FSM
//   state encodings, the default request-buffer depth and a small
//   elaboration helper used for parameter sanity checks.
package fpu_issue_controller_pkg;

    // 2-bit operation codes understood by the fixed-point unit.
    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_SUB  = 2'd1,
        FPU_MUL  = 2'd2,
        FPU_SQRT = 2'd3
    } fpu_op_e;

    // Issue FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } issue_state_e;

    localparam int FPU_FIFO_DEPTH_DEFAULT = 2;

    // True when v is a power of two and at least 2.
    function automatic logic is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fpu_issue_controller_req_fifo.sv
// fpu_req_fifo
//   Synchronous request buffer for the FPU issue stage. Stores packed
//   {op, operand_1, operand_2, tag} words. A push while full and a pop
//   while empty are ignored; a push and a pop in the same cycle are both
//   honoured. Read data is the current head (show-ahead).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties FIFO)
//   push, push_data   write request / data
//   pop               remove head entry
//   pop_data          head entry
//   full, empty       occupancy flags
module fpu_req_fifo
    import fpu_issue_controller_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = FPU_FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fpu_req_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller
//   Dispatch stage in front of the fixed-point unit. Requests from decode
//   are buffered in fpu_req_fifo and issued one at a time; operands and
//   operation are held on the FPU inputs until fpu_ready, then the result
//   and destination tag are offered to writeback over valid/ready.
//
//   Optional feature (macro FPU_ISSUE_TIMEOUT_EN): an EXEC watchdog. If the
//   FPU has not reported ready after TIMEOUT_CYCLES EXEC cycles the request
//   completes with wb_result=0 and wb_error=1. Without the macro EXEC waits
//   indefinitely and wb_error is constant 0.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake from decode
//   req_op, req_operand_1/2, req_tag  request payload
//   fpu_operand_1/2, fpu_operation  held FPU inputs
//   fpu_start                       one-cycle pulse when a request issues
//   fpu_result, fpu_ready           FPU completion (only 1'b1 is ready)
//   wb_valid/wb_ready               writeback handshake
//   wb_result, wb_tag, wb_error     completion payload
//   busy                            FIFO non-empty or FSM not idle
module fpu_issue_controller
    import fpu_issue_controller_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TAG_W          = 5,
    parameter int FIFO_DEPTH     = FPU_FIFO_DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    output logic             fpu_start,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_error,
    output logic             busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fpu_issue_controller: TIMEOUT_CYCLES must be >= 1");
    end

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] operand_1;
        logic [WIDTH-1:0] operand_2;
        logic [TAG_W-1:0] tag;
    } fpu_req_t;

    fpu_req_t     push_req;
    fpu_req_t     head_req;
    logic         fifo_full;
    logic         fifo_empty;
    logic         issue;
    logic         fpu_done;
    logic [TAG_W-1:0] issue_tag;
    issue_state_e state;

    assign push_req = '{op:        req_op,
                        operand_1: req_operand_1,
                        operand_2: req_operand_2,
                        tag:       req_tag};

    fpu_req_fifo #(
        .DATA_W ($bits(fpu_req_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (issue),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    // X/Z on fpu_ready must not complete a request, hence the explicit compare.
    assign fpu_done = (fpu_ready == 1'b1);

    // Issue from IDLE, or straight from WB on accept so back-to-back
    // requests skip the IDLE bubble.
    assign issue = !fifo_empty &&
                   ((state == ST_IDLE) || ((state == ST_WB) && wb_ready));

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] exec_cnt;
    logic             exec_timeout;

    // exec_cnt counts completed EXEC cycles; the limit fires on the edge
    // that ends the TIMEOUT_CYCLES-th EXEC cycle.
    assign exec_timeout = (state == ST_EXEC) &&
                          (exec_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt <= '0;
        end else if (issue) begin
            exec_cnt <= '0;
        end else if (state == ST_EXEC) begin
            exec_cnt <= exec_cnt + 1'b1;
        end
    end
`else
    assign wb_error = 1'b0;
`endif

    // Issue registers: loaded on pop, held otherwise (including IDLE/WB).
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            fpu_operation <= '0;
            issue_tag     <= '0;
            fpu_start     <= 1'b0;
        end else begin
            fpu_start <= issue;
            if (issue) begin
                fpu_operand_1 <= head_req.operand_1;
                fpu_operand_2 <= head_req.operand_2;
                fpu_operation <= head_req.op;
                issue_tag     <= head_req.tag;
            end
        end
    end

    // Issue FSM with registered writeback outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_tag    <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wb_error  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (fpu_done) begin
                        wb_valid  <= 1'b1;
                        wb_result <= fpu_result;
                        wb_tag    <= issue_tag;
`ifdef FPU_ISSUE_TIMEOUT_EN
                        wb_error  <= 1'b0;
`endif
                        state     <= ST_WB;
`ifdef FPU_ISSUE_TIMEOUT_EN
                    end else if (exec_timeout) begin
                        wb_valid  <= 1'b1;
                        wb_result <= '0;
                        wb_tag    <= issue_tag;
                        wb_error  <= 1'b1;
                        state     <= ST_WB;
`endif
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= fifo_empty ? ST_IDLE : ST_EXEC;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// tb_fpu_issue_controller
//   Scoreboard bench for fpu_issue_controller. A behavioural FPU with
//   programmable latency answers issued requests; expected completions are
//   queued when a request is accepted and checked at the writeback
//   handshake. Outputs are sampled on the falling edge.
module tb_fpu_issue_controller;
    import fpu_issue_controller_pkg::*;

    localparam int WIDTH          = 32;
    localparam int TAG_W          = 5;
    localparam int FIFO_DEPTH     = 2;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int FBITS          = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_operand_1;
    logic [WIDTH-1:0] req_operand_2;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic             fpu_start;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_result;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_error;
    logic             busy;

    always #5 clk = ~clk;

    fpu_issue_controller #(
        .WIDTH          (WIDTH),
        .TAG_W          (TAG_W),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_operand_1 (req_operand_1),
        .req_operand_2 (req_operand_2),
        .req_tag       (req_tag),
        .fpu_operand_1 (fpu_operand_1),
        .fpu_operand_2 (fpu_operand_2),
        .fpu_operation (fpu_operation),
        .fpu_start     (fpu_start),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_result     (wb_result),
        .wb_tag        (wb_tag),
        .wb_error      (wb_error),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int n_done = 0;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural FPU ----------------
    // fpu_latency = EXEC cycle in which ready rises (1 = first cycle); 0 = never.
    int fpu_latency = 1;
    int fcnt = 0;
    int fcur;

    always_comb fcur = fpu_start ? 1 : fcnt;
    always @(posedge clk) fcnt <= fcur + 1;
    assign fpu_ready = (fpu_latency != 0) && (fcur >= fpu_latency);

    function automatic logic [WIDTH-1:0] fpu_calc(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [63:0] prod;
        logic [63:0] x;
        logic [31:0] r;
        logic [31:0] t;
        case (op)
            FPU_ADD: return a + b;
            FPU_SUB: return a - b;
            FPU_MUL: begin
                prod = 64'(a) * 64'(b);
                return prod[FBITS +: WIDTH];
            end
            default: begin
                x = 64'(a) << FBITS;
                r = '0;
                for (int i = 31; i >= 0; i--) begin
                    t = r | (32'd1 << i);
                    if (64'(t) * 64'(t) <= x) r = t;
                end
                return r;
            end
        endcase
    endfunction

    assign fpu_result = fpu_calc(fpu_operation, fpu_operand_1, fpu_operand_2);

    // ---------------- completion monitor ----------------
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_result", wb_result, e.result);
                chk("wb_tag", wb_tag, e.tag);
                chk("wb_error", wb_error, e.err);
            end
            done_cyc.push_back(cycle);
            n_done++;
        end
    end

    // ---------------- helpers (all start and end at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                        input logic [WIDTH-1:0] exp_res, input logic exp_err);
        int n = 0;
        req_valid     = 1'b1;
        req_op        = op;
        req_operand_1 = a;
        req_operand_2 = b;
        req_tag       = tag;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_accept_timeout", 0, 1);
        else exp_q.push_back('{exp_res, tag, exp_err});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int starts;
        int done_before;

        reset = 1'b1; req_valid = 1'b0; req_op = '0;
        req_operand_1 = '0; req_operand_2 = '0; req_tag = '0;
        wb_ready = 1'b0;
        tick(3);

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_wb_error", wb_error, 0);
        chk("rst_fpu_op", {fpu_operation, fpu_operand_1, fpu_operand_2}, 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // ADD, ready in first EXEC cycle: accept E0, issue E1, wb_valid after E2
        wb_ready = 1'b1; fpu_latency = 1;
        send(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd3, 32'h0000_1000, 1'b0);
        @(negedge clk);
        chk("add_no_bypass_start", fpu_start, 0);
        chk("add_busy", busy, 1);
        @(negedge clk);
        chk("add_issue_start", fpu_start, 1);
        chk("add_issue_op", fpu_operation, FPU_ADD);
        chk("add_issue_a", fpu_operand_1, 32'h0000_0C00);
        chk("add_issue_b", fpu_operand_2, 32'h0000_0400);
        chk("add_exec_wb_valid", wb_valid, 0);
        @(negedge clk);
        chk("add_latency_wb_valid", wb_valid, 1);
        @(negedge clk);
        chk("add_after_accept_valid", wb_valid, 0);
        chk("add_after_accept_busy", busy, 0);
        tick(1);
        drain();

        // MUL, ready in 5th EXEC cycle: inputs held, one start pulse
        fpu_latency = 5;
        send(FPU_MUL, 32'h0000_0800, 32'h0000_0600, 5'd7, 32'h0000_0C00, 1'b0);
        starts = 0;
        @(negedge clk);
        starts += int'(fpu_start);
        @(negedge clk);
        starts += int'(fpu_start);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            starts += int'(fpu_start);
            chk("mul_hold_op", fpu_operation, FPU_MUL);
            chk("mul_hold_a", fpu_operand_1, 32'h0000_0800);
            chk("mul_hold_b", fpu_operand_2, 32'h0000_0600);
            chk("mul_exec_wb_valid", wb_valid, 0);
        end
        @(negedge clk);
        starts += int'(fpu_start);
        chk("mul_wb_valid", wb_valid, 1);
        chk("mul_start_pulses", starts, 1);
        tick(1);
        drain();

        // Back-to-back with writeback stalled: fill FIFO, then release
        wb_ready = 1'b0; fpu_latency = 1;
        send(FPU_ADD, 32'h0000_0100, 32'h0000_0200, 5'd10, 32'h0000_0300, 1'b0);
        send(FPU_SUB, 32'h0000_0500, 32'h0000_0100, 5'd11, 32'h0000_0400, 1'b0);
        send(FPU_ADD, 32'h0000_07FF, 32'h0000_0001, 5'd12, 32'h0000_0800, 1'b0);
        req_valid = 1'b1; req_op = FPU_MUL;
        req_operand_1 = 32'h0000_0400; req_operand_2 = 32'h0000_0400; req_tag = 5'd13;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_req_ready", req_ready, 0);
            chk("full_wb_valid", wb_valid, 1);
        end
        tick(1);
        done_cyc.delete();
        wb_ready = 1'b1;
        send(FPU_MUL, 32'h0000_0400, 32'h0000_0400, 5'd13, 32'h0000_0400, 1'b0);
        drain();
        chk("b2b_count", done_cyc.size(), 4);
        if (done_cyc.size() == 4) begin
            for (int k = 0; k < 3; k++)
                chk("b2b_spacing", done_cyc[k+1] - done_cyc[k], 2);
        end

        // SQRT with writeback held off: payload stable until accepted
        wb_ready = 1'b0; fpu_latency = 2;
        send(FPU_SQRT, 32'h0000_1000, 32'h0000_DEAD, 5'd21, 32'h0000_0800, 1'b0);
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sqrt_wb_valid_seen", wb_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("sqrt_hold_valid", wb_valid, 1);
            chk("sqrt_hold_result", wb_result, 32'h0000_0800);
            chk("sqrt_hold_tag", wb_tag, 5'd21);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        drain();

        // Reset during EXEC with two entries queued
        fpu_latency = 0;
        send(FPU_ADD, 32'h0000_0001, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0);
        send(FPU_ADD, 32'h0000_0002, 32'h0000_0002, 5'd2, 32'h0000_0004, 1'b0);
        send(FPU_ADD, 32'h0000_0003, 32'h0000_0003, 5'd4, 32'h0000_0006, 1'b0);
        tick(2);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_req_ready", req_ready, 0);
        done_before = n_done;
        reset = 1'b1;
        exp_q.delete();
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        fpu_latency = 1;
        tick(20);
        chk("mid_rst_no_completion", n_done, done_before);

        // EXEC watchdog
        fpu_latency = 0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        send(FPU_MUL, 32'h0000_0123, 32'h0000_0456, 5'd9, 32'h0000_0000, 1'b1);
        n = 0;
        @(negedge clk);
        while (!fpu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_issue_seen", fpu_start, 1);
        n = 1;
        while (!wb_valid && n < 50) begin
            @(negedge clk);
            if (!wb_valid) n++;
        end
        chk("to_exec_cycles", n, TIMEOUT_CYCLES);
        chk("to_wb_error", wb_error, 1);
        chk("to_wb_result", wb_result, 0);
        chk("to_hold_op", fpu_operation, FPU_MUL);
        tick(1);
        drain();
`else
        send(FPU_MUL, 32'h0000_0123, 32'h0000_0456, 5'd9, 32'h0000_0000, 1'b0);
        repeat (100) @(negedge clk);
        chk("noto_wb_valid", wb_valid, 0);
        chk("noto_busy", busy, 1);
        chk("noto_hold_op", fpu_operation, FPU_MUL);
        chk("noto_wb_error", wb_error, 0);
        tick(1);
        reset = 1'b1;
        exp_q.delete();
        tick(1);
        reset = 1'b0;
        tick(2);
`endif

        chk("end_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
